// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg -- shared UART types, parity encodings and bit timing.   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Shared with uart_rx so both ends agree on the bit period.
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    function automatic logic calc_parity(input logic [7:0] data,
                                         input int         data_bits,
                                         input int         mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < data_bits) begin
                p = p ^ data[i];
            end
        end
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_if -- valid/ready byte handshake into the transmitter.    |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface uart_tx_if;

    logic       valid_in;
    logic [7:0] data_in;
    logic       ready_out;

    modport master (
        output valid_in,
        output data_in,
        input  ready_out
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output ready_out
    );

endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_bit_timer -- counts 0..CLKS_PER_BIT-1, pulses bit_done.      |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic restart,
    input  logic enable,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_done = enable && (count == LAST_COUNT);

    // Counter wraps on bit_done so consecutive bits need no explicit restart.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (restart || bit_done || !enable) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx -- UART frame transmitter: start, data LSB first, parity, |
// | stop bits. Revision 1.0                                           |
// +------------------------------------------------------------------+
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     n_rst,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     busy
);

    localparam int             SHIFT_W   = DATA_BITS + 1;
    localparam logic [2:0]     LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

    uart_tx_state_t     state;
    uart_tx_state_t     state_next;
    logic [SHIFT_W-1:0] shift_reg;
    logic [SHIFT_W-1:0] shift_next;
    logic [SHIFT_W-1:0] load_word;
    logic [2:0]         bit_cnt;
    logic [2:0]         bit_cnt_next;
    logic               stop_cnt;
    logic               stop_cnt_next;
    logic               tx_next;
    logic               ready_next;
    logic               busy_next;
    logic               accept;
    logic               bit_done;

    assign accept = bus.valid_in && bus.ready_out;

    // Parity sits just above the data bits so it falls out of the shifter last.
    always_comb begin
        load_word                  = '0;
        load_word[DATA_BITS-1:0]   = bus.data_in[DATA_BITS-1:0];
        load_word[DATA_BITS]       = calc_parity(bus.data_in, DATA_BITS, PARITY_MODE);
    end

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .restart  (accept),
        .enable   (state != IDLE),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            stop_cnt      <= 1'b0;
            tx            <= 1'b1;
            bus.ready_out <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            shift_reg     <= shift_next;
            bit_cnt       <= bit_cnt_next;
            stop_cnt      <= stop_cnt_next;
            tx            <= tx_next;
            bus.ready_out <= ready_next;
            busy          <= busy_next;
        end
    end

    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        tx_next       = tx;
        ready_next    = bus.ready_out;
        busy_next     = busy;

        case (state)
            IDLE: begin
                tx_next    = 1'b1;
                ready_next = 1'b1;
                busy_next  = 1'b0;
                if (accept) begin
                    state_next    = START;
                    shift_next    = load_word;
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                    tx_next       = 1'b0;
                    ready_next    = 1'b0;
                    busy_next     = 1'b1;
                end
            end

            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == LAST_DATA) begin
                        if (PARITY_MODE != PARITY_NONE) begin
                            state_next = PARITY;
                            tx_next    = shift_reg[0];
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        tx_next      = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                    end
                end
            end

            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                        ready_next = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        stop_cnt_next = stop_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                ready_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx -- directed bench with a frame-decoding scoreboard.    |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_uart_tx;
    import uart_pkg::*;

    logic clk;
    logic n_rst;
    logic tx_def, busy_def;
    logic tx_even, busy_even;
    logic tx_odd, busy_odd;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];

    uart_tx_if if_def ();
    uart_tx_if if_even ();
    uart_tx_if if_odd ();

    uart_tx u_def (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if_def),
        .tx    (tx_def),
        .busy  (busy_def)
    );

    uart_tx #(.PARITY_MODE(PARITY_EVEN), .STOP_BITS(2)) u_even (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if_even),
        .tx    (tx_even),
        .busy  (busy_even)
    );

    uart_tx #(.PARITY_MODE(PARITY_ODD), .STOP_BITS(1)) u_odd (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if_odd),
        .tx    (tx_odd),
        .busy  (busy_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (if_def.ready_out !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, if_def.ready_out}, 32'd1);
    endtask

    // Decodes every default-config frame at mid-bit and pops its expected byte.
    logic [9:0] mon_frame;
    logic       mon_abort;
    logic [7:0] mon_exp;
    always begin
        @(negedge clk);
        if (n_rst === 1'b1 && tx_def === 1'b0) begin
            mon_abort = 1'b0;
            mon_frame = '0;
            for (int c = 0; c <= 152; c++) begin
                if (n_rst !== 1'b1) mon_abort = 1'b1;
                else if (c % 16 == 8) mon_frame[c / 16] = tx_def;
                if (mon_abort) break;
                if (c < 152) @(negedge clk);
            end
            if (!mon_abort) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    mon_exp = sb.pop_front();
                    check("frame_bits", {22'd0, mon_frame}, {22'd0, 1'b1, mon_exp, 1'b0});
                end
            end
        end
    end

    // Holds valid_in so the second byte is taken in the first idle cycle.
    task automatic b2b(input logic [7:0] a, input logic [7:0] b);
        int   gap;
        logic idle_tx;
        if_def.valid_in = 1'b1;
        if_def.data_in  = a;
        sb.push_back(a);
        @(negedge clk);
        check("b2b_accept1", {31'd0, busy_def}, 32'd1);
        repeat (40) @(negedge clk);
        if_def.data_in = b;
        sb.push_back(b);
        gap = 40;
        @(negedge clk);
        gap++;
        check("b2b_ignore_ready", {31'd0, if_def.ready_out}, 32'd0);
        while (busy_def === 1'b1 && gap < 400) begin
            @(negedge clk);
            gap++;
        end
        idle_tx = tx_def;
        check("b2b_idle_ready", {31'd0, if_def.ready_out}, 32'd1);
        @(negedge clk);
        gap++;
        if_def.valid_in = 1'b0;
        check("b2b_gap", gap, 32'd161);
        check("b2b_idle_tx", {31'd0, idle_tx}, 32'd1);
        check("b2b_start2", {30'd0, busy_def, tx_def}, 32'b10);
        wait_ready("b2b_done");
    endtask

    initial begin
        int         len;
        int         len_e;
        int         len_o;
        logic [11:0] fe;
        logic [11:0] fo;
        logic [7:0]  pb;

        n_rst = 1'b0;
        if_def.valid_in  = 1'b1;
        if_def.data_in   = 8'hA5;
        if_even.valid_in = 1'b0;
        if_even.data_in  = 8'h00;
        if_odd.valid_in  = 1'b0;
        if_odd.data_in   = 8'h00;

        // Reset values, with valid_in already asserted
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx_def}, 32'd1);
        check("rst_ready", {31'd0, if_def.ready_out}, 32'd0);
        check("rst_busy", {31'd0, busy_def}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        check("release_ready", {31'd0, if_def.ready_out}, 32'd1);
        check("release_no_accept", {31'd0, busy_def}, 32'd0);
        sb.push_back(8'hA5);
        @(negedge clk);
        if_def.valid_in = 1'b0;
        check("accept_state", {29'd0, busy_def, if_def.ready_out, tx_def}, 32'b100);

        // Busy duration of one default frame
        len = 1;
        while (len < 400) begin
            @(negedge clk);
            if (busy_def !== 1'b1) break;
            len++;
        end
        check("busy_len", len, 32'd160);
        check("ready_after", {31'd0, if_def.ready_out}, 32'd1);

        // Back-to-back frames; data_in changes mid-frame
        @(negedge clk);
        b2b(8'hA5, 8'h55);
        b2b(8'h00, 8'hFF);

        // Reset in the middle of a frame
        if_def.valid_in = 1'b1;
        if_def.data_in  = 8'h3C;
        @(negedge clk);
        if_def.valid_in = 1'b0;
        check("rst_frame_accept", {31'd0, busy_def}, 32'd1);
        repeat (50) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("rst_async_tx", {31'd0, tx_def}, 32'd1);
        check("rst_mid_ready", {31'd0, if_def.ready_out}, 32'd0);
        check("rst_mid_busy", {31'd0, busy_def}, 32'd0);
        repeat (10) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_mid_release", {30'd0, if_def.ready_out, tx_def}, 32'b11);
        if_def.valid_in = 1'b1;
        if_def.data_in  = 8'h81;
        sb.push_back(8'h81);
        @(negedge clk);
        if_def.valid_in = 1'b0;
        check("after_rst_accept", {31'd0, busy_def}, 32'd1);
        wait_ready("after_rst_done");

        // Even parity with two stop bits, odd parity with one
        pb = 8'h07;
        if_even.valid_in = 1'b1;
        if_even.data_in  = pb;
        if_odd.valid_in  = 1'b1;
        if_odd.data_in   = pb;
        @(negedge clk);
        if_even.valid_in = 1'b0;
        if_odd.valid_in  = 1'b0;
        len_e = 0;
        len_o = 0;
        fe = '0;
        fo = '0;
        for (int c = 0; c < 200; c++) begin
            if (busy_even === 1'b1) len_e++;
            if (busy_odd === 1'b1) len_o++;
            if (c % 16 == 8) begin
                fe[c / 16] = tx_even;
                fo[c / 16] = tx_odd;
            end
            @(negedge clk);
        end
        check("even_frame", {20'd0, fe}, {20'd0, 2'b11, ^pb, pb, 1'b0});
        check("odd_frame", {20'd0, fo}, {20'd0, 2'b11, ~(^pb), pb, 1'b0});
        check("even_len", len_e, 32'd192);
        check("odd_len", len_o, 32'd176);

        repeat (20) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
